mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001: Parameter WIDTH, default 32, operand and HI/LO register width.
REQ-002: clk  input  1  single clock; all state changes on rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005: alu_ctrl  input  4  operation code: MULTUac=7, DIVUac=8, MFHIac=9, MFLOac=10; all other codes are no-op here.
REQ-006: a  input  WIDTH  unsigned multiplicand / dividend.
REQ-007: b  input  WIDTH  unsigned multiplier / divisor.
REQ-008: busy  output  1  high whenever state is not IDLE.
REQ-009: done  output  1  one-cycle pulse; HI/LO hold the new result in that cycle.
REQ-010: hi  output  WIDTH  HI register (product upper half / remainder).
REQ-011: lo  output  WIDTH  LO register (product lower half / quotient).
REQ-012: result  output  WIDTH  combinational: hi when alu_ctrl=MFHIac, lo when alu_ctrl=MFLOac, else 0.
REQ-013: div_by_zero  output  1  sticky flag for the last accepted DIVU having b=0.

Function
REQ-014: FSM states SHALL be IDLE, MULT, DIV, DONE.
REQ-015: IDLE with start=1 and alu_ctrl=MULTUac: latch a, b; clear counter and accumulator; go to MULT.
REQ-016: IDLE with start=1, alu_ctrl=DIVUac, b!=0: latch a, b; clear counter and partial remainder; go to DIV.
REQ-017: IDLE with start=1, alu_ctrl=DIVUac, b=0: hi<=a, lo<=all ones, div_by_zero<=1; go directly to DONE.
REQ-018: IDLE with start=1 and any other alu_ctrl: no state change, no register write.
REQ-019: MULT: one shift-add iteration per cycle, exactly WIDTH cycles; on the last iteration write the 2*WIDTH product {hi,lo}; go to DONE.
REQ-020: DIV: one restoring-division iteration per cycle, exactly WIDTH cycles; on the last iteration lo<=quotient, hi<=remainder; go to DONE.
REQ-021: Counter SHALL count 0..WIDTH-1 and be cleared on every accepted start.
REQ-022: DONE SHALL assert done for exactly one cycle, then go unconditionally to IDLE.
REQ-023: Latency: start accepted in cycle 0 -> busy in cycles 1..WIDTH+1, done in cycle WIDTH+1 (33 for WIDTH=32); divide-by-zero -> done in cycle 1.
REQ-024: start in MULT, DIV or DONE SHALL be ignored; latched operands SHALL be unaffected by input changes while busy.
REQ-025: hi and lo SHALL keep their previous values until the final iteration write; result reads the pre-operation values while busy.
REQ-026: Every accepted start SHALL clear div_by_zero, except a DIVU with b=0, which sets it.
REQ-027: All arithmetic is unsigned; the product is never truncated.

Reset
REQ-028: rst_n=0 SHALL immediately force state=IDLE, counter=0, hi=0, lo=0, div_by_zero=0, busy=0, done=0.
REQ-029: Reset during MULT or DIV SHALL abort the operation; no done pulse or partial result appears after release.
REQ-030: The first start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-031: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> cycle 33 done=1, hi=0xFFFFFFFE, lo=0x00000001; busy=0 in cycle 34.
REQ-032: DIVU a=100, b=7 -> cycle 33 done=1, lo=14, hi=2, div_by_zero=0.
REQ-033: DIVU a=5, b=0 -> cycle 1 done=1, hi=5, lo=0xFFFFFFFF, div_by_zero=1; a following MULTU 3*4 -> lo=12, hi=0, div_by_zero=0.
REQ-034: MULTU 6*7, then start=1 with DIVU 9/3 in cycle 10 -> second request ignored; cycle 33 lo=42, hi=0; no second done.
REQ-035: MULTU started, rst_n=0 in cycle 10 -> hi=lo=0 and busy=0 immediately; done never pulses.
REQ-036: After DIVU 100/7: alu_ctrl=MFHIac -> result=2, MFLOac -> result=14; start=1 with alu_ctrl=ADDac(2) -> busy stays 0.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// mult_div_unit request/result bundle.
// Master drives the request, slave returns status and HI/LO.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, alu_ctrl, a, b,
    input  busy, done, hi, lo, result, div_by_zero
  );

  modport slave (
    input  start, alu_ctrl, a, b,
    output busy, done, hi, lo, result, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative unsigned MULTU/DIVU unit with HI/LO registers.
// One shift-add or restoring-divide step per cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_div_unit_if.slave bus
);

  localparam logic [3:0] MULTU = 4'd7;
  localparam logic [3:0] DIVU  = 4'd8;
  localparam logic [3:0] MFHI  = 4'd9;
  localparam logic [3:0] MFLO  = 4'd10;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               dbz_q, dbz_d;

  logic               last;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;

  // One multiply step and one divide step from the current state
  always_comb begin
    last    = (cnt_q == CW'(WIDTH - 1));
    addend  = b_q[cnt_q] ? a_q : {WIDTH{1'b0}};
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + {1'b0, addend};
    acc_nx  = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh  = {rem_q, a_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, b_q};
    q_bit   = ~rem_sub[WIDTH];
    rem_nx  = q_bit ? rem_sub[WIDTH-1:0]
                    : rem_sh[WIDTH-1:0];
    quo_nx  = {a_q[WIDTH-2:0], q_bit};
  end

  // Next-state and register updates for the operation FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && bus.alu_ctrl == MULTU) begin
          a_d     = bus.a;
          b_d     = bus.b;
          cnt_d   = '0;
          acc_d   = '0;
          dbz_d   = 1'b0;
          state_d = MULT;
        end else if (bus.start && bus.alu_ctrl == DIVU
                     && bus.b != '0) begin
          a_d     = bus.a;
          b_d     = bus.b;
          cnt_d   = '0;
          rem_d   = '0;
          dbz_d   = 1'b0;
          state_d = DIV;
        end else if (bus.start && bus.alu_ctrl == DIVU) begin
          hi_d    = bus.a;
          lo_d    = '1;
          dbz_d   = 1'b1;
          state_d = DONE;
        end
      end
      MULT: begin
        acc_d = acc_nx;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          hi_d    = acc_nx[2*WIDTH-1:WIDTH];
          lo_d    = acc_nx[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DIV: begin
        rem_d = rem_nx;
        a_d   = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          lo_d    = quo_nx;
          hi_d    = rem_nx;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      dbz_q   <= dbz_d;
    end
  end

  // Status outputs and the MFHI/MFLO read mux
  always_comb begin
    bus.busy        = (state_q != IDLE);
    bus.done        = (state_q == DONE);
    bus.hi          = hi_q;
    bus.lo          = lo_q;
    bus.div_by_zero = dbz_q;
    bus.result      = '0;
    if (bus.alu_ctrl == MFHI) bus.result = hi_q;
    if (bus.alu_ctrl == MFLO) bus.result = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit.
// Random operands against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  localparam logic [3:0] MULTU = 4'd7;
  localparam logic [3:0] DIVU  = 4'd8;
  localparam logic [3:0] MFHI  = 4'd9;
  localparam logic [3:0] MFLO  = 4'd10;
  localparam logic [3:0] ADD   = 4'd2;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   chk_cnt;

  logic [31:0] hi_m;
  logic [31:0] lo_m;
  logic        dbz_m;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model(input logic [3:0] op,
                       input logic [31:0] x,
                       input logic [31:0] y);
    logic [63:0] p;
    if (op == MULTU) begin
      p = {32'b0, x} * {32'b0, y};
      hi_m = p[63:32];
      lo_m = p[31:0];
      dbz_m = 1'b0;
    end else if (op == DIVU) begin
      if (y == 0) begin
        hi_m = x;
        lo_m = 32'hFFFF_FFFF;
        dbz_m = 1'b1;
      end else begin
        lo_m = x / y;
        hi_m = x % y;
        dbz_m = 1'b0;
      end
    end
  endtask

  function automatic int exp_lat(input logic [3:0] op,
                                 input logic [31:0] y);
    return (op == DIVU && y == 0) ? 1 : 33;
  endfunction

  // Issue one request; lat = cycle of done (0 on timeout),
  // held = HI/LO stable and busy high until done.
  task automatic do_op(input logic [3:0] op,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       output int lat,
                       output bit held);
    logic [31:0] h0, l0;
    @(negedge clk);
    rst_n = 1'b1;
    h0 = bus.hi;
    l0 = bus.lo;
    bus.start = 1'b1;
    bus.alu_ctrl = op;
    bus.a = x;
    bus.b = y;
    lat = 0;
    held = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
      end
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      if (bus.hi !== h0 || bus.lo !== l0 || bus.busy !== 1'b1)
        held = 1'b0;
    end
  endtask

  task automatic test_reset();
    int lat;
    bit held;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.alu_ctrl = 4'd0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000)
      $display("FAIL rst_flags got %b want 000",
               {bus.busy, bus.done, bus.div_by_zero});
    else pass_cnt++;
    chk_cnt++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0)
      $display("FAIL rst_hilo got %h_%h want 0_0", bus.hi, bus.lo);
    else pass_cnt++;
    hi_m = 0;
    lo_m = 0;
    dbz_m = 0;
    do_op(MULTU, 32'd2, 32'd3, lat, held);
    model(MULTU, 32'd2, 32'd3);
    chk_cnt++;
    if (lat !== 33)
      $display("FAIL first_start_lat got %0d want 33", lat);
    else pass_cnt++;
    chk_cnt++;
    if (bus.lo !== lo_m || bus.hi !== hi_m)
      $display("FAIL first_start_val got %h_%h want %h_%h",
               bus.hi, bus.lo, hi_m, lo_m);
    else pass_cnt++;
  endtask

  task automatic test_mult();
    int lat;
    bit held;
    logic [31:0] x, y;
    do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, held);
    chk_cnt++;
    if (lat !== 33) $display("FAIL mult_max_lat got %0d want 33", lat);
    else pass_cnt++;
    chk_cnt++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001)
      $display("FAIL mult_max got %h_%h want fffffffe_00000001",
               bus.hi, bus.lo);
    else pass_cnt++;
    model(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    chk_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL mult_after busy=%b done=%b want 0 0",
               bus.busy, bus.done);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      x = $urandom;
      y = (k == 0) ? 32'd0 : $urandom;
      do_op(MULTU, x, y, lat, held);
      model(MULTU, x, y);
      chk_cnt++;
      if (lat !== 33) $display("FAIL mult_lat got %0d want 33", lat);
      else pass_cnt++;
      chk_cnt++;
      if (bus.hi !== hi_m || bus.lo !== lo_m)
        $display("FAIL mult_rand %h*%h got %h_%h want %h_%h",
                 x, y, bus.hi, bus.lo, hi_m, lo_m);
      else pass_cnt++;
      chk_cnt++;
      if (held !== 1'b1) $display("FAIL mult_hold got %b want 1", held);
      else pass_cnt++;
    end
  endtask

  task automatic test_div();
    int lat;
    bit held;
    logic [31:0] x, y;
    do_op(DIVU, 32'd100, 32'd7, lat, held);
    model(DIVU, 32'd100, 32'd7);
    chk_cnt++;
    if (lat !== 33) $display("FAIL div_lat got %0d want 33", lat);
    else pass_cnt++;
    chk_cnt++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2
        || bus.div_by_zero !== 1'b0)
      $display("FAIL div_100_7 got q=%0d r=%0d dz=%b want 14 2 0",
               bus.lo, bus.hi, bus.div_by_zero);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      if (k == 0) y = 32'd1;
      if (k == 1) y = x;
      if (y == 0) y = 32'd3;
      do_op(DIVU, x, y, lat, held);
      model(DIVU, x, y);
      chk_cnt++;
      if (lat !== 33) $display("FAIL div_lat got %0d want 33", lat);
      else pass_cnt++;
      chk_cnt++;
      if (bus.hi !== hi_m || bus.lo !== lo_m)
        $display("FAIL div_rand %h/%h got r=%h q=%h want r=%h q=%h",
                 x, y, bus.hi, bus.lo, hi_m, lo_m);
      else pass_cnt++;
      chk_cnt++;
      if (held !== 1'b1) $display("FAIL div_hold got %b want 1", held);
      else pass_cnt++;
    end
  endtask

  task automatic test_div_zero();
    int lat;
    bit held;
    do_op(DIVU, 32'd5, 32'd0, lat, held);
    model(DIVU, 32'd5, 32'd0);
    chk_cnt++;
    if (lat !== 1) $display("FAIL dz_lat got %0d want 1", lat);
    else pass_cnt++;
    chk_cnt++;
    if (bus.hi !== 32'd5 || bus.lo !== 32'hFFFF_FFFF
        || bus.div_by_zero !== 1'b1)
      $display("FAIL dz_val got %h_%h dz=%b want 5_ffffffff 1",
               bus.hi, bus.lo, bus.div_by_zero);
    else pass_cnt++;
    do_op(MULTU, 32'd3, 32'd4, lat, held);
    model(MULTU, 32'd3, 32'd4);
    chk_cnt++;
    if (bus.lo !== 32'd12 || bus.hi !== 32'd0
        || bus.div_by_zero !== 1'b0)
      $display("FAIL dz_clear got %h_%h dz=%b want 0_c 0",
               bus.hi, bus.lo, bus.div_by_zero);
    else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int ndone;
    int first;
    @(negedge clk);
    bus.start = 1'b1;
    bus.alu_ctrl = MULTU;
    bus.a = 32'd6;
    bus.b = 32'd7;
    model(MULTU, 32'd6, 32'd7);
    ndone = 0;
    first = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 10) begin
        bus.start = 1'b1;
        bus.alu_ctrl = DIVU;
        bus.a = 32'd9;
        bus.b = 32'd3;
      end
      if (i == 11) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        if (first == 0) first = i;
      end
    end
    chk_cnt++;
    if (first !== 33 || ndone !== 1)
      $display("FAIL ign_done got cyc=%0d n=%0d want 33 1",
               first, ndone);
    else pass_cnt++;
    chk_cnt++;
    if (bus.lo !== 32'd42 || bus.hi !== 32'd0 || bus.busy !== 1'b0)
      $display("FAIL ign_val got %h_%h busy=%b want 0_2a 0",
               bus.hi, bus.lo, bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int ndone;
    bit moved;
    @(negedge clk);
    bus.start = 1'b1;
    bus.alu_ctrl = MULTU;
    bus.a = 32'hFFFF_FFFF;
    bus.b = 32'h1234_5678;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    hi_m = 0;
    lo_m = 0;
    dbz_m = 0;
    chk_cnt++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0)
      $display("FAIL abort_now got %h_%h busy=%b want 0_0 0",
               bus.hi, bus.lo, bus.busy);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    moved = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
      if (bus.hi !== 32'd0 || bus.lo !== 32'd0) moved = 1'b1;
    end
    chk_cnt++;
    if (ndone !== 0 || moved !== 1'b0)
      $display("FAIL abort_after got done=%0d moved=%b want 0 0",
               ndone, moved);
    else pass_cnt++;
  endtask

  task automatic test_result_mux();
    int lat;
    bit held;
    bit seen;
    do_op(DIVU, 32'd100, 32'd7, lat, held);
    model(DIVU, 32'd100, 32'd7);
    @(negedge clk);
    bus.alu_ctrl = MFHI;
    #1;
    chk_cnt++;
    if (bus.result !== 32'd2)
      $display("FAIL mfhi got %0d want 2", bus.result);
    else pass_cnt++;
    bus.alu_ctrl = MFLO;
    #1;
    chk_cnt++;
    if (bus.result !== 32'd14)
      $display("FAIL mflo got %0d want 14", bus.result);
    else pass_cnt++;
    bus.alu_ctrl = MULTU;
    #1;
    chk_cnt++;
    if (bus.result !== 32'd0)
      $display("FAIL res_other got %0d want 0", bus.result);
    else pass_cnt++;
    @(negedge clk);
    bus.start = 1'b1;
    bus.alu_ctrl = ADD;
    @(negedge clk);
    bus.start = 1'b0;
    chk_cnt++;
    if (bus.busy !== 1'b0 || bus.hi !== hi_m || bus.lo !== lo_m)
      $display("FAIL noop busy=%b hilo=%h_%h want 0 %h_%h",
               bus.busy, bus.hi, bus.lo, hi_m, lo_m);
    else pass_cnt++;
    bus.start = 1'b1;
    bus.alu_ctrl = MULTU;
    bus.a = 32'd1000;
    bus.b = 32'd1000;
    model(MULTU, 32'd1000, 32'd1000);
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        bus.alu_ctrl = MFLO;
      end
      if (i == 5) begin
        chk_cnt++;
        if (bus.result !== 32'd14)
          $display("FAIL res_busy got %0d want 14", bus.result);
        else pass_cnt++;
      end
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk_cnt++;
    if (seen !== 1'b1 || bus.result !== lo_m)
      $display("FAIL res_final done=%b got %0d want 1 %0d",
               seen, bus.result, lo_m);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    bit held;
    int sel;
    logic [3:0] op;
    logic [31:0] x, y;
    for (int k = 0; k < 10; k++) begin
      sel = $urandom_range(0, 3);
      x = $urandom;
      y = $urandom >> $urandom_range(0, 24);
      op = (sel == 0) ? MULTU : (sel == 3) ? ADD : DIVU;
      if (sel == 2) y = 32'd0;
      if (sel == 1 && y == 0) y = 32'd5;
      if (op == ADD) begin
        @(negedge clk);
        bus.start = 1'b1;
        bus.alu_ctrl = op;
        @(negedge clk);
        bus.start = 1'b0;
        chk_cnt++;
        if (bus.busy !== 1'b0 || bus.hi !== hi_m || bus.lo !== lo_m)
          $display("FAIL b2b_noop busy=%b got %h_%h want %h_%h",
                   bus.busy, bus.hi, bus.lo, hi_m, lo_m);
        else pass_cnt++;
      end else begin
        do_op(op, x, y, lat, held);
        model(op, x, y);
        chk_cnt++;
        if (lat !== exp_lat(op, y))
          $display("FAIL b2b_lat op=%0d got %0d want %0d",
                   op, lat, exp_lat(op, y));
        else pass_cnt++;
        chk_cnt++;
        if (bus.hi !== hi_m || bus.lo !== lo_m
            || bus.div_by_zero !== dbz_m)
          $display("FAIL b2b_val op=%0d got %h_%h dz=%b want %h_%h %b",
                   op, bus.hi, bus.lo, bus.div_by_zero,
                   hi_m, lo_m, dbz_m);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_result_mux();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
